// File: rtl/uart_pkg.sv
// Shared parity constants, FSM state type and parity helper for the UART transmitter.
package uart_pkg;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_ODD    = 1;
    localparam int PARITY_EVEN   = 2;

    localparam int MAX_DATA_BITS = 9;
    localparam int BIT_IDX_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Data is zero-extended to MAX_DATA_BITS, so the padding never changes the count of ones.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input int mode);
        logic ones_odd;
        ones_odd = ^data;
        case (mode)
            PARITY_ODD:  return ~ones_odd;
            PARITY_EVEN: return ones_odd;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered head data; used by uart_tx_frame when UART_TX_FIFO_EN is defined.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rd_data_o
);
    import uart_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] stored;
    logic             empty_q;
    logic [WIDTH-1:0] rd_data_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        // Only entries written before this edge are visible to the head register.
        stored   = count_q - CNT_W'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= (stored == '0);
            rd_data_q <= mem_q[rd_ptr_d];
        end
    end

    assign full_o    = (count_q == DEPTH_CNT);
    assign empty_o   = empty_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: valid/ready word stream in, async frames out on uart_txd, back-to-back capable.
// Define UART_TX_FIFO_EN to replace the one-entry holding register with a FIFO_DEPTH-entry FIFO.
module uart_tx_frame #(
    parameter int SYS_PERIOD = 100_000_000,
    parameter int BPS        = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_txd,
    output logic                 tx_busy,
    output logic                 tx_done,
    output uart_pkg::tx_state_t  dbg_state_o
);
    import uart_pkg::*;

    localparam int BIT_CYCLES = SYS_PERIOD / BPS;
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [BIT_IDX_W-1:0] DATA_LAST = BIT_IDX_W'(DATA_BITS - 1);
    localparam logic [BIT_IDX_W-1:0] STOP_LAST = BIT_IDX_W'(STOP_BITS - 1);

    if (BIT_CYCLES < 2) begin : g_bad_baud
        $error("uart_tx_frame: SYS_PERIOD/BPS must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_width
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
    // tx_data is sampled only at that edge and tx_ready never depends on tx_valid.
    logic                 accept;
    logic                 pending;
    logic [DATA_BITS-1:0] pend_data;
    logic                 load;

    assign accept = tx_valid && tx_ready;

`ifdef UART_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (accept),
        .wr_data_i (tx_data),
        .pop_i     (load),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .rd_data_o (pend_data)
    );

    assign tx_ready = !fifo_full;
    assign pending  = !fifo_empty;
`else
    logic                 hold_valid_q, hold_valid_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        // A word arriving in the same cycle the slot drains must survive the load.
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = tx_data;
        end else if (load) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign tx_ready  = !hold_valid_q;
    assign pending   = hold_valid_q;
    assign pend_data = hold_data_q;
`endif

    tx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [BIT_IDX_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 bit_end;
    logic                 data_end;
    logic                 stop_end;

    assign bit_end  = (baud_cnt_q == BIT_LAST);
    assign data_end = bit_end && (bit_cnt_q == DATA_LAST);
    assign stop_end = bit_end && (bit_cnt_q == STOP_LAST);
    assign load     = pending && ((state_q == IDLE) || (state_q == STOP && stop_end));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:             if (pending)  state_d = START;
            START:            if (bit_end)  state_d = DATA;
            DATA:             if (data_end) state_d = (PARITY != PARITY_NONE) ? uart_pkg::PARITY : STOP;
            uart_pkg::PARITY: if (bit_end)  state_d = STOP;
            STOP:             if (stop_end) state_d = pending ? START : IDLE;
            default:          state_d = IDLE;
        endcase
    end

    always_comb begin
        uart_txd = 1'b1;
        tx_busy  = (state_q != IDLE);
        tx_done  = 1'b0;
        unique case (state_q)
            START:            uart_txd = 1'b0;
            DATA:             uart_txd = shift_q[0];
            uart_pkg::PARITY: uart_txd = parity_q;
            STOP:             tx_done  = stop_end;
            default:          ;
        endcase
    end

    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;

        if (state_q == IDLE || bit_end) begin
            baud_cnt_d = '0;
        end else begin
            baud_cnt_d = baud_cnt_q + 1'b1;
        end

        // bit_cnt indexes data bits in DATA and stop bits in STOP; every state entry restarts it.
        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end else if (bit_end) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        if (load) begin
            shift_d  = pend_data;
            parity_d = calc_parity(MAX_DATA_BITS'(pend_data), PARITY);
        end else if (state_q == DATA && bit_end) begin
            shift_d = shift_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises words presented on a valid/ready stream into asynchronous frames with configurable data width, parity and stop-bit count. It sits between any byte-producing logic (receiver loop-back, command engine, debug path) and the `uart_txd` pin. It accepts a new word while a frame is on the line, so consecutive frames go out with no idle gap. An optional internal FIFO decouples bursty producers.

## Interface
Parameters:
- `SYS_PERIOD`, 100_000_000, system clock frequency in Hz
- `BPS`, 115_200, line baud rate
- `DATA_BITS`, 8, data bits per frame; legal range 5–9
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even
- `STOP_BITS`, 1, stop bits per frame; 1 or 2
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥2; used only when the FIFO is compiled in

Ports:
- One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `tx_data`  in  DATA_BITS  word to send, LSB first
- `tx_valid`  in  1  `tx_data` is valid
- `tx_ready`  out  1  block can accept a word this cycle
- `uart_txd`  out  1  serial line, idle high
- `tx_busy`  out  1  a frame is on the line
- `tx_done`  out  1  one-cycle pulse in the last cycle of the final stop bit

## Operation
- `BIT_CYCLES = SYS_PERIOD/BPS`, using truncating integer division; elaboration fails if it is below 2.
- The baud counter is `$clog2(BIT_CYCLES)` bits wide. It counts 0..BIT_CYCLES-1 and wraps to 0.
- A word is accepted on a rising edge where `tx_valid && tx_ready`. `tx_data` is sampled at that edge only.
- Without the FIFO, a one-entry holding register stores the accepted word. `tx_ready` is high while the holding register is empty.
- State machine:
  - IDLE → START when a word is pending. The pending word is loaded into the shift register and the holding slot is freed.
  - START → DATA after BIT_CYCLES cycles.
  - DATA sends DATA_BITS bits, LSB first. It then goes to PARITY if `PARITY≠0`, otherwise to STOP.
  - PARITY → STOP after BIT_CYCLES cycles.
  - STOP lasts STOP_BITS×BIT_CYCLES cycles. At its last cycle it goes to START if another word is pending, otherwise to IDLE.
- Line levels per state:
  - START drives 0.
  - DATA drives the current shift-register bit.
  - PARITY drives the parity bit. Odd parity makes the total count of ones in data+parity odd; even parity makes it even.
  - STOP and IDLE drive 1.
- Parity is computed over the loaded word at load time.
- `tx_busy` is high in every state except IDLE.
- `tx_data` changes after acceptance have no effect on a frame in flight.

## Timing
- Reset values: `uart_txd`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0. The state machine is in IDLE, the holding register or FIFO is empty, and the baud counter is 0.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BIT_CYCLES cycles. Every bit lasts exactly BIT_CYCLES cycles.
- Latency, no FIFO, block idle: a word accepted at edge N drives `uart_txd` low from edge N+1.
- Latency, FIFO compiled in, block idle: a word accepted at edge N drives `uart_txd` low from edge N+2.
- Back-to-back: if a word is pending when STOP ends, its start bit begins at the next edge. No idle cycle is inserted.
- Simultaneous accept and load from the holding register in the same cycle is legal. The new word is retained.
- Reset asserted mid-frame: at the next edge `uart_txd` returns to 1 and all pending words are discarded. The truncated frame is not resumed.

## Configuration
- Macro: `UART_TX_FIFO_EN`.
- Defined:
  - A FIFO of FIFO_DEPTH entries replaces the holding register.
  - `tx_ready` = FIFO not full.
  - The FIFO is popped when the state machine loads a word.
  - Simultaneous push and pop on a full FIFO is not allowed, because `tx_ready` is low then.
- Undefined: the one-entry holding register is used and FIFO_DEPTH is ignored.

## Structure
- Package `uart_pkg`:
  - parity mode constants `PARITY_NONE`, `PARITY_ODD`, `PARITY_EVEN`
  - state typedef `tx_state_t` with states IDLE, START, DATA, PARITY, STOP
- Sub-module `uart_tx_fifo`: synchronous FIFO with parameters width and depth. Its outputs are `full`, `empty` and registered read data. It is instantiated only under `UART_TX_FIFO_EN`.

## Test plan
All cases use SYS_PERIOD=100_000_000 and BPS=10_000_000, so BIT_CYCLES=10.
- 8N1, send 0x55 → `uart_txd` shows 0,1,0,1,0,1,0,1,0,1 with 10 cycles per bit. `tx_done` pulses at cycle 100 after the start bit. `tx_busy` is high for exactly 100 cycles.
- 8E1, send 0x07 → parity bit is 1 and the frame is 110 cycles. With 8O1 the same word gives parity bit 0.
- 7N2, send 0x7F → seven 1 data bits followed by 20 cycles of stop. Data bit 7 is never driven.
- No FIFO, send 0xA5 then 0x3C with `tx_valid` held high → the second start bit begins exactly 100 cycles after the first. `tx_ready` is low while 0x3C is held.
- `UART_TX_FIFO_EN`, FIFO_DEPTH=4, drive `tx_valid` high continuously → exactly 5 words are accepted before `tx_ready` first falls. All 5 frames leave in order with no gaps.
- Assert `rst` for 1 cycle at cycle 35 of a 0x00 frame → `uart_txd`=1 from the next edge and `tx_ready`=1. A new word sent afterwards produces a clean frame.
